// File: rtl/binary_multiplier_seq.sv
// Sequential shift-and-add multiplier: A = Q*B + R (unsigned).
// One partial product per cycle in RUN, then a one-cycle DONE pulse.
// Optional: define BINARY_MULTIPLIER_SEQ_EARLY_EXIT_EN to leave RUN as soon as
// the remaining multiplier bits are all zero (result is identical, latency shrinks).
module binary_multiplier_seq #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   Q,
    input  logic [SIZE-1:0]   B,
    input  logic [SIZE-1:0]   R,
    output logic [2*SIZE-1:0] A,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(SIZE) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [SIZE-1:0]     q_q;
    logic [SIZE-1:0]     b_q;
    logic [2*SIZE-1:0]   acc_q;
    logic [CW-1:0]       cnt_q;

    logic [2*SIZE-1:0]   partial;
    logic [2*SIZE-1:0]   acc_next;
    logic [SIZE-1:0]     b_shift;
    logic                last_step;

    // Partial product for the current step; the step counter doubles as the shift amount.
    always_comb begin
        partial  = {{SIZE{1'b0}}, q_q} << cnt_q;
        acc_next = b_q[0] ? (acc_q + partial) : acc_q;
        b_shift  = b_q >> 1;
    end

`ifdef BINARY_MULTIPLIER_SEQ_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain; the counter bound is a backstop.
    assign last_step = (b_shift == '0) || (cnt_q == CW'(SIZE - 1));
`else
    assign last_step = (cnt_q == CW'(SIZE - 1));
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_step) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    // Datapath: operand capture, accumulate/shift, result load on the last RUN step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            A     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        q_q   <= Q;
                        b_q   <= B;
                        acc_q <= {{SIZE{1'b0}}, R};
                        cnt_q <= '0;
                    end
                end
                StRun: begin
                    acc_q <= acc_next;
                    b_q   <= b_shift;
                    cnt_q <= cnt_q + CW'(1);
                    // A is written only here, so it holds steady through RUN.
                    if (last_step) A <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_multiplier_seq.sv
// Bench for binary_multiplier_seq (SIZE=8). A timeline model predicts busy/done/A
// each cycle from the accept edge, run length and Q*B+R; directed vectors pin
// latency and results with literal values.
module tb_binary_multiplier_seq;

    localparam int SIZE = 8;
`ifdef BINARY_MULTIPLIER_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  q = '0, b = '0, r = '0;
    logic [15:0] a;
    logic        busy, done;

    int n_vec = 0;
    int n_err = 0;

    binary_multiplier_seq #(.SIZE(SIZE)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .Q    (q),
        .B    (b),
        .R    (r),
        .A    (a),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Number of RUN cycles the operation should take.
    function automatic int run_len(input logic [7:0] bb);
        int hi;
        hi = 0;
        if (!EE) return SIZE;
        for (int i = 0; i < SIZE; i++) if (bb[i]) hi = i + 1;
        return (hi == 0) ? 1 : hi;
    endfunction

    // Timeline model: an accepted op at edge s is RUN for L intervals, DONE in
    // interval s+L, and the machine is ready again after edge s+L+1.
    int          cyc = 0;
    int          m_s = 0;
    int          m_l = 0;
    bit          m_active = 1'b0;
    logic [15:0] m_res = '0;
    logic [15:0] m_a = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
                m_a      = '0;
            end else begin
                cyc++;
                if (m_active) begin
                    if (cyc == m_s + m_l) m_a = m_res;
                    if (cyc == m_s + m_l + 1) m_active = 1'b0;
                end else if (start) begin
                    m_active = 1'b1;
                    m_s      = cyc;
                    m_l      = run_len(b);
                    m_res    = 16'(int'(q) * int'(b) + int'(r));
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, m_active && (cyc < m_s + m_l)});
        chk("done", {31'b0, done}, {31'b0, m_active && (cyc == m_s + m_l)});
        chk("a", {16'b0, a}, {16'b0, m_a});
        chk("busy_and_done", {31'b0, busy && done}, 32'd0);
    end

    // One start pulse; measures cycles (start edge = cycle 0) to the done pulse.
    task automatic run_op(input logic [7:0] qq, input logic [7:0] bb, input logic [7:0] rr,
                          input logic [15:0] ea, input int elat, input string tag);
        int n;
        bit seen;
        @(posedge clk); #1;
        q = qq; b = bb; r = rr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_a"}, {16'b0, a}, {16'b0, ea});
    endtask

    initial begin
        int ndone;
        int first;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a", {16'b0, a}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(8'd13, 8'd10, 8'd7, 16'h0089, EE ? 5 : 9, "basic");
        run_op(8'd255, 8'd255, 8'd254, 16'hFEFF, 9, "max");
        run_op(8'd200, 8'd0, 8'd9, 16'd9, EE ? 2 : 9, "b_zero");
        run_op(8'd7, 8'd1, 8'd0, 16'd7, EE ? 2 : 9, "b_one");
        run_op(8'd2, 8'd128, 8'd0, 16'd256, 9, "b_msb");
        run_op(8'd0, 8'd77, 8'd33, 16'd33, EE ? 8 : 9, "q_zero");

        // Second start mid-RUN with other operands must be ignored.
        @(posedge clk); #1;
        q = 8'd13; b = 8'd10; r = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk); #1;
        q = 8'd1; b = 8'd1; r = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first = 0;
        for (int i = 4; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        chk("ignore_ndone", ndone, 1);
        chk("ignore_lat", first, EE ? 5 : 9);
        chk("ignore_a", {16'b0, a}, 32'h0089);

        // Reset in cycle 4 of RUN aborts without a done pulse.
        @(posedge clk); #1;
        q = 8'd13; b = 8'd255; r = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_a", {16'b0, a}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        run_op(8'd3, 8'd5, 8'd2, 16'd17, EE ? 4 : 9, "after_rst");

        // start held high restarts at every IDLE.
        @(posedge clk); #1;
        q = 8'd9; b = 8'd9; r = 8'd1; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("held_ndone", ndone, EE ? 3 : 2);
        chk("held_a", {16'b0, a}, 32'd82);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
